player_physics: RTL and testbench

Per-frame motion and collision-response engine for one fighter. On each `frame_tick` it integrates walk input, jump and gravity into a candidate position, drives the candidate to the combinational collision checker one axis at a time, and resolves the returned flags into a committed position and velocity. It sits between the controller input logic and the sprite renderer, and is the consumer of the checker's `{left,right,bottom,top}` flags.

---
 rtl/player_physics.sv | 143 ++++++++++++++
 tb/tb_player_physics.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/player_physics.sv
// player_physics: per-frame walk/jump/gravity integration with axis-by-axis collision response; define PHYSICS_DOUBLE_JUMP_EN to allow one air jump
module player_physics #(
  parameter logic [15:0] START_X    = 16'd100,
  parameter logic [15:0] START_Y    = 16'd100,
  parameter logic [15:0] X_MAX      = 16'd639,
  parameter logic [15:0] Y_MAX      = 16'd479,
  parameter logic [7:0]  WALK_SPEED = 8'd3,
  parameter logic [7:0]  JUMP_VEL   = 8'd12,
  parameter logic [7:0]  GRAVITY    = 8'd1,
  parameter logic [7:0]  MAX_FALL   = 8'd8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              frame_tick,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_jump,
  input  logic [31:0]       player_size,
  input  logic [31:0]       stage_pos,
  input  logic [31:0]       stage_size,
  input  logic [3:0]        coll,
  output logic [31:0]       probe_pos,
  output logic [31:0]       player_pos,
  output logic signed [7:0] vel_x,
  output logic signed [7:0] vel_y,
  output logic              grounded,
  output logic [1:0]        jumps_left,
  output logic              busy,
  output logic              done,
  output logic              ko
);
`ifdef PHYSICS_DOUBLE_JUMP_EN
  localparam logic [1:0] JMAX = 2'd2;
`else
  localparam logic [1:0] JMAX = 2'd1;
`endif
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CALC    = 3'd1;
  localparam logic [2:0] PROBE_X = 3'd2;
  localparam logic [2:0] PROBE_Y = 3'd3;
  localparam logic [2:0] COMMIT  = 3'd4;
  logic [2:0] state;
  logic l, r, jump_edge, jump_prev;
  logic [15:0] x, y, px, py;
  logic signed [7:0] vx, vy;
  logic [16:0] sx, sy;
  logic [8:0] vy_fall;
  logic unused_bits;
  assign unused_bits = ^{player_size[31:16], stage_pos[31:16], stage_size[31:16]};
  assign sx = {1'b0, x} + {{9{vx[7]}}, vx};
  assign sy = {1'b0, y} + {{9{vy[7]}}, vy};
  assign px = sx[16] ? 16'd0 : (sx[15:0] > X_MAX ? X_MAX : sx[15:0]);
  assign py = sy[16] ? 16'd0 : sy[15:0];
  assign vy_fall = {vy[7], vy} + {GRAVITY[7], GRAVITY};
  assign probe_pos = state == PROBE_X ? {px, y} : state == PROBE_Y ? {x, py} : {x, y};
  assign busy = state != IDLE;
  // frame sequencer: working x/y/vx/vy always equal the committed values while idle
  always_ff @(posedge clock)
    if (!reset_n) begin
      state      <= IDLE;
      x          <= START_X;
      y          <= START_Y;
      vx         <= '0;
      vy         <= '0;
      player_pos <= {START_X, START_Y};
      vel_x      <= '0;
      vel_y      <= '0;
      grounded   <= 1'b0;
      jumps_left <= JMAX;
      done       <= 1'b0;
      ko         <= 1'b0;
      l          <= 1'b0;
      r          <= 1'b0;
      jump_edge  <= 1'b0;
      jump_prev  <= 1'b0;
    end else begin
      done <= 1'b0;
      ko   <= 1'b0;
      case (state)
        IDLE:
          if (frame_tick) begin
            state     <= CALC;
            l         <= btn_left;
            r         <= btn_right;
            jump_edge <= btn_jump & ~jump_prev;
            jump_prev <= btn_jump;
          end
        CALC: begin
          state <= PROBE_X;
          vx    <= (l & ~r) ? 8'd0 - WALK_SPEED : (r & ~l) ? WALK_SPEED : 8'd0;
          if (jump_edge && jumps_left != 2'd0) begin
            vy         <= 8'd0 - JUMP_VEL;
            jumps_left <= jumps_left - 2'd1;
            grounded   <= 1'b0;
          end else
            vy <= $signed(vy_fall) > $signed({MAX_FALL[7], MAX_FALL}) ? MAX_FALL : vy_fall[7:0];
        end
        PROBE_X: begin
          state <= PROBE_Y;
          if ((vx[7] && coll[3]) || (!vx[7] && vx != 8'sd0 && coll[2]))
            vx <= '0;
          else
            x <= px;
        end
        PROBE_Y: begin
          state <= COMMIT;
          if (!vy[7] && coll[1]) begin
            y          <= stage_pos[15:0] - player_size[15:0];
            vy         <= '0;
            grounded   <= 1'b1;
            jumps_left <= JMAX;
          end else if (vy[7] && coll[0]) begin
            y  <= stage_pos[15:0] + stage_size[15:0];
            vy <= '0;
          end else begin
            y        <= py;
            grounded <= 1'b0;
          end
        end
        COMMIT: begin
          state <= IDLE;
          done  <= 1'b1;
          if (y > Y_MAX) begin
            x          <= START_X;
            y          <= START_Y;
            vx         <= '0;
            vy         <= '0;
            player_pos <= {START_X, START_Y};
            vel_x      <= '0;
            vel_y      <= '0;
            jumps_left <= JMAX;
            grounded   <= 1'b0;
            ko         <= 1'b1;
          end else begin
            player_pos <= {x, y};
            vel_x      <= vx;
            vel_y      <= vy;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_player_physics.sv
// tb_player_physics: table-driven frames with an expected-result queue, plus protocol and double-jump sequences
module tb_player_physics;
`ifdef PHYSICS_DOUBLE_JUMP_EN
  localparam int JM = 2;
`else
  localparam int JM = 1;
`endif
  localparam logic [63:0] G = {16'd0, 16'd200, 16'd640, 16'd20};
  localparam logic [63:0] N = {16'd1000, 16'd1000, 16'd1, 16'd1};
  localparam logic [63:0] W = {16'd118, 16'd100, 16'd20, 16'd200};
  localparam logic [63:0] H = {16'd0, 16'd100, 16'd640, 16'd60};
  localparam logic [2:0] NO = 3'b000, L = 3'b100, R = 3'b010, J = 3'b001, LR = 3'b110;
  typedef struct { bit chk; int x, y, vx, vy, g, j, k; } exp_t;
  typedef struct { logic [2:0] btn; logic [63:0] st; int reps; exp_t e; } row_t;
  logic clk = 1'b0, reset_n = 1'b0, frame_tick = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic [31:0] player_size = {16'd16, 16'd32};
  logic [31:0] stage_pos = N[63:32], stage_size = N[31:0];
  logic [31:0] probe_pos, player_pos;
  logic [3:0] coll;
  logic signed [7:0] vel_x, vel_y;
  logic grounded, busy, done, ko;
  logic [1:0] jumps_left;
  int tests = 0, fails = 0;
  exp_t q[$];
  exp_t got;
  row_t tbl[$];

  player_physics dut (
    .clock(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .player_size(player_size), .stage_pos(stage_pos), .stage_size(stage_size),
    .coll(coll), .probe_pos(probe_pos), .player_pos(player_pos),
    .vel_x(vel_x), .vel_y(vel_y), .grounded(grounded), .jumps_left(jumps_left),
    .busy(busy), .done(done), .ko(ko)
  );

  always #5 clk = ~clk;

  // rectangle-overlap checker: any overlap raises all four flags, the engine picks by direction
  assign coll = {4{int'(probe_pos[31:16]) < int'(stage_pos[31:16]) + int'(stage_size[31:16]) &&
                   int'(probe_pos[31:16]) + int'(player_size[31:16]) > int'(stage_pos[31:16]) &&
                   int'(probe_pos[15:0]) < int'(stage_pos[15:0]) + int'(stage_size[15:0]) &&
                   int'(probe_pos[15:0]) + int'(player_size[15:0]) > int'(stage_pos[15:0])}};

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic row_t mk(input logic [2:0] b, input logic [63:0] st, input int reps, x, y, vx, vy, g, j, k);
    row_t rw;
    rw.btn = b; rw.st = st; rw.reps = reps;
    rw.e = '{1'b1, x, y, vx, vy, g, j, k};
    return rw;
  endfunction

  // scoreboard: every done pops one expected frame result
  always @(negedge clk)
    if (done) begin
      if (q.size() == 0) check("unexpected_done", int'(done), 0);
      else begin
        got = q.pop_front();
        check("vy_saturation", int'(vel_y > 8'sd8), 0);
        if (got.chk) begin
          check("pos_x", int'(player_pos[31:16]), got.x);
          check("pos_y", int'(player_pos[15:0]), got.y);
          check("vel_x", int'(vel_x), got.vx);
          check("vel_y", int'(vel_y), got.vy);
          check("grounded", int'(grounded), got.g);
          check("jumps_left", int'(jumps_left), got.j);
          check("ko", int'(ko), got.k);
        end
      end
    end

  task automatic frame(input row_t rw);
    exp_t e;
    for (int k = 0; k < rw.reps; k++) begin
      @(negedge clk);
      {btn_left, btn_right, btn_jump} = rw.btn;
      stage_pos = rw.st[63:32];
      stage_size = rw.st[31:0];
      frame_tick = 1'b1;
      e = rw.e;
      e.chk = (k == rw.reps - 1);
      q.push_back(e);
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    {btn_left, btn_right, btn_jump} = NO;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl.push_back(mk(NO, G, 12, 100, 168, 0, 8, 0, JM, 0));
    tbl.push_back(mk(NO, G, 1, 100, 168, 0, 0, 1, JM, 0));
    tbl.push_back(mk(J, G, 1, 100, 156, 0, -12, 0, JM - 1, 0));
    tbl.push_back(mk(J, G, 1, 100, 145, 0, -11, 0, JM - 1, 0));
    tbl.push_back(mk(NO, G, 25, 100, 168, 0, 0, 1, JM, 0));
    tbl.push_back(mk(R, W, 1, 100, 169, 0, 1, 0, JM, 0));
    tbl.push_back(mk(R, W, 1, 100, 171, 0, 2, 0, JM, 0));
    tbl.push_back(mk(NO, G, 1, 100, 168, 0, 0, 1, JM, 0));
    tbl.push_back(mk(L, G, 33, 1, 168, -3, 0, 1, JM, 0));
    tbl.push_back(mk(L, G, 1, 0, 168, -3, 0, 1, JM, 0));
    tbl.push_back(mk(L, G, 1, 0, 168, -3, 0, 1, JM, 0));
    tbl.push_back(mk(LR, G, 1, 0, 168, 0, 0, 1, JM, 0));
    tbl.push_back(mk(J, H, 1, 0, 160, 0, 0, 0, JM - 1, 0));
    tbl.push_back(mk(NO, G, 4, 0, 168, 0, 0, 1, JM, 0));
    tbl.push_back(mk(NO, N, 42, 0, 476, 0, 8, 0, JM, 0));
    tbl.push_back(mk(NO, N, 1, 100, 100, 0, 0, 0, JM, 1));
    tbl.push_back(mk(NO, N, 1, 100, 101, 0, 1, 0, JM, 0));

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_pos", int'(player_pos), int'({16'd100, 16'd100}));
    check("rst_probe", int'(probe_pos), int'({16'd100, 16'd100}));
    check("rst_vel_x", int'(vel_x), 0);
    check("rst_vel_y", int'(vel_y), 0);
    check("rst_grounded", int'(grounded), 0);
    check("rst_jumps", int'(jumps_left), JM);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ko", int'(ko), 0);

    @(negedge clk);
    frame_tick = 1'b1;
    q.push_back('{1'b1, 100, 101, 0, 1, 0, JM, 0});
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      frame_tick = (c == 2 || c == 4);
      if (c < 5) begin
        check("done_early", int'(done), 0);
        check("busy_mid", int'(busy), 1);
      end else begin
        check("done_latency", int'(done), 1);
        check("busy_end", int'(busy), 0);
      end
    end
    repeat (8) @(negedge clk);
    check("ignored_tick_pos", int'(player_pos), int'({16'd100, 16'd101}));

    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    check("probe_x_phase", int'(probe_pos), int'({16'd100, 16'd101}));
    @(negedge clk);
    check("probe_y_phase", int'(probe_pos), int'({16'd100, 16'd103}));
    check("stable_pos", int'(player_pos), int'({16'd100, 16'd101}));
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_pos", int'(player_pos), int'({16'd100, 16'd100}));
    check("abort_done", int'(done), 0);
    check("abort_vel_y", int'(vel_y), 0);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_idle", int'(busy), 0);

    for (int i = 0; i < tbl.size(); i++) frame(tbl[i]);

    reset_pulse();
    frame(mk(NO, G, 13, 100, 168, 0, 0, 1, JM, 0));
    frame(mk(J, G, 1, 100, 156, 0, -12, 0, JM - 1, 0));
    frame(mk(NO, G, 1, 100, 145, 0, -11, 0, JM - 1, 0));
`ifdef PHYSICS_DOUBLE_JUMP_EN
    frame(mk(J, G, 1, 100, 133, 0, -12, 0, 0, 0));
    frame(mk(NO, G, 1, 100, 122, 0, -11, 0, 0, 0));
    frame(mk(J, G, 1, 100, 112, 0, -10, 0, 0, 0));
`else
    frame(mk(J, G, 1, 100, 135, 0, -10, 0, 0, 0));
    frame(mk(NO, G, 1, 100, 126, 0, -9, 0, 0, 0));
    frame(mk(J, G, 1, 100, 118, 0, -8, 0, 0, 0));
`endif

    repeat (10) @(negedge clk);
    check("missing_done", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
